// File: rtl/mem_access_stage.sv
// Memory access stage: lane steering, byte enables and load extension around a
// req/ack data-memory port, stalling upstream until the access completes or times out.
module mem_access_stage #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic        MemToRegM,
   input  logic        RegWriteM,
   input  logic [1:0]  MemTypeM,
   input  logic [31:0] ALUresultM,
   input  logic [31:0] ReadData2M,
   input  logic [4:0]  WriteRegM,
   input  logic [31:0] PCPlus4M,
   output logic        StallM,
   output logic        DMemReq,
   output logic        DMemWe,
   output logic [31:0] DMemAddr,
   output logic [31:0] DMemWData,
   output logic [3:0]  DMemByteEn,
   input  logic        DMemAck,
   input  logic [31:0] DMemRData,
   output logic        RegWriteW,
   output logic        MemToRegW,
   output logic [31:0] ALUresultW,
   output logic [31:0] ReadDataW,
   output logic [31:0] PCPlus4W,
   output logic [4:0]  WriteRegW,
   output logic        MisalignW,
   output logic        BusErrW
);

   // state | meaning
   // IDLE  | no access outstanding; a legal access requests combinationally
   // WAIT  | request held, waiting for DMemAck or the timeout terminal count
   typedef enum logic {IDLE, WAIT} stateT;

   stateT       state, stateNext;
   logic [7:0]  cnt, cntNext;
   logic        reqInt, stallInt, timeoutHit;
   logic        isAccess, isWord, isHalf, isByte, misalign, legal;
   logic [1:0]  offs;
   logic [31:0] shifted, loadData;

   assign offs     = ALUresultM[1:0];
   assign isAccess = MemReadM | MemWriteM;
   assign isWord   = (MemTypeM == 2'b00);
   assign isHalf   = (MemTypeM == 2'b01);
   assign isByte   = MemTypeM[1];
   assign misalign = isAccess & ((isHalf & offs[0]) | (isWord & (offs != 2'b00)));
   assign legal    = isAccess & ~misalign;

   assign DMemAddr = {ALUresultM[31:2], 2'b00};
   assign DMemWe   = MemWriteM;

   always_comb begin
      DMemByteEn = 4'b1111;
      DMemWData  = ReadData2M;
      if (isHalf) begin
         DMemByteEn = offs[1] ? 4'b1100 : 4'b0011;
         DMemWData  = {2{ReadData2M[15:0]}};
      end else if (isByte) begin
         DMemByteEn = 4'b0001 << offs;
         DMemWData  = {4{ReadData2M[7:0]}};
      end
   end

   assign shifted = DMemRData >> {offs, 3'b000};

   always_comb begin
      loadData = DMemRData;
      case (MemTypeM)
         2'b01:   loadData = {{16{shifted[15]}}, shifted[15:0]};
         2'b10:   loadData = {{24{shifted[7]}}, shifted[7:0]};
         2'b11:   loadData = {24'h0, shifted[7:0]};
         default: loadData = DMemRData;
      endcase
   end

   // Timeout is a down-counter: loaded with TIMEOUT-1 on entering WAIT, expires at zero.
   always_comb begin
      stateNext  = state;
      cntNext    = cnt;
      reqInt     = 1'b0;
      stallInt   = 1'b0;
      timeoutHit = 1'b0;
      case (state)
         IDLE: begin
            if (legal) begin
               reqInt = 1'b1;
               if (!DMemAck) begin
                  stallInt  = 1'b1;
                  stateNext = WAIT;
                  cntNext   = 8'(TIMEOUT - 1);
               end
            end
         end
         WAIT: begin
            if (DMemAck) begin
               reqInt    = 1'b1;
               stateNext = IDLE;
               cntNext   = '0;
            end else if (cnt == 8'd0) begin
               timeoutHit = 1'b1;
               stateNext  = IDLE;
            end else begin
               reqInt   = 1'b1;
               stallInt = 1'b1;
               cntNext  = cnt - 8'd1;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Reset must kill the request and stall even while inputs still present an access.
   assign DMemReq = reqInt & Rst_n;
   assign StallM  = stallInt & Rst_n;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         RegWriteW  <= 1'b0;
         MemToRegW  <= 1'b0;
         ALUresultW <= '0;
         ReadDataW  <= '0;
         PCPlus4W   <= '0;
         WriteRegW  <= '0;
         MisalignW  <= 1'b0;
         BusErrW    <= 1'b0;
      end else begin
         ALUresultW <= ALUresultM;
         PCPlus4W   <= PCPlus4M;
         WriteRegW  <= WriteRegM;
         RegWriteW  <= RegWriteM;
         MemToRegW  <= MemToRegM;
         ReadDataW  <= '0;
         MisalignW  <= 1'b0;
         BusErrW    <= 1'b0;
         if (stallInt) begin
            RegWriteW <= 1'b0;
            MemToRegW <= 1'b0;
         end else if (misalign) begin
            MisalignW <= 1'b1;
            RegWriteW <= 1'b0;
            MemToRegW <= 1'b0;
         end else if (timeoutHit) begin
            BusErrW   <= 1'b1;
            RegWriteW <= 1'b0;
            MemToRegW <= 1'b0;
         end else if (isAccess && !MemWriteM) begin
            ReadDataW <= loadData;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: comb port checks inline, W-slot results
// pushed to a scoreboard queue and compared by an independent monitor.
module tb_mem_access_stage;
   logic        Clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic        MemReadM, MemWriteM, MemToRegM, RegWriteM;
   logic [1:0]  MemTypeM;
   logic [31:0] ALUresultM, ReadData2M, PCPlus4M;
   logic [4:0]  WriteRegM;
   logic        StallM, DMemReq, DMemWe, DMemAck;
   logic [31:0] DMemAddr, DMemWData, DMemRData;
   logic [3:0]  DMemByteEn;
   logic        RegWriteW, MemToRegW, MisalignW, BusErrW;
   logic [31:0] ALUresultW, ReadDataW, PCPlus4W;
   logic [4:0]  WriteRegW;

   mem_access_stage #(.TIMEOUT(4)) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .MemReadM(MemReadM), .MemWriteM(MemWriteM), .MemToRegM(MemToRegM), .RegWriteM(RegWriteM),
      .MemTypeM(MemTypeM), .ALUresultM(ALUresultM), .ReadData2M(ReadData2M),
      .WriteRegM(WriteRegM), .PCPlus4M(PCPlus4M), .StallM(StallM),
      .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemWData(DMemWData),
      .DMemByteEn(DMemByteEn), .DMemAck(DMemAck), .DMemRData(DMemRData),
      .RegWriteW(RegWriteW), .MemToRegW(MemToRegW), .ALUresultW(ALUresultW),
      .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .WriteRegW(WriteRegW),
      .MisalignW(MisalignW), .BusErrW(BusErrW)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic        regWrite, memToReg, chkM2r, misalign, busErr, chkRd, chkData;
      logic [31:0] readData, aluResult, pcPlus4;
      logic [4:0]  writeReg;
   } wExpT;

   wExpT  expQ[$];
   string nameQ[$];
   wExpT  monE;
   string monName;
   int    checks = 0;
   int    errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic setM(input logic rd, input logic wr, input logic m2r, input logic rw,
                       input logic [1:0] typ, input logic [31:0] alu, input logic [31:0] rd2,
                       input logic [4:0] wreg, input logic [31:0] pc4);
      MemReadM = rd; MemWriteM = wr; MemToRegM = m2r; RegWriteM = rw;
      MemTypeM = typ; ALUresultM = alu; ReadData2M = rd2; WriteRegM = wreg; PCPlus4M = pc4;
   endtask

   task automatic setMem(input logic ack, input logic [31:0] rdata);
      DMemAck = ack; DMemRData = rdata;
   endtask

   task automatic reqStall(input string nm, input logic req, input logic stall);
      chk({nm, ":DMemReq"}, 32'(DMemReq), 32'(req));
      chk({nm, ":StallM"}, 32'(StallM), 32'(stall));
   endtask

   task automatic pushW(input string nm, input logic rw, input logic m2r, input logic chkM2r,
                        input logic mis, input logic be, input logic chkRd, input logic [31:0] rdv,
                        input logic chkData, input logic [31:0] alu, input logic [4:0] wr,
                        input logic [31:0] pc);
      wExpT e;
      e.regWrite = rw; e.memToReg = m2r; e.chkM2r = chkM2r; e.misalign = mis; e.busErr = be;
      e.chkRd = chkRd; e.readData = rdv; e.chkData = chkData;
      e.aluResult = alu; e.writeReg = wr; e.pcPlus4 = pc;
      expQ.push_back(e);
      nameQ.push_back(nm);
   endtask

   task automatic pushBubble(input string nm);
      pushW(nm, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 32'h0);
   endtask

   initial begin : monitor
      forever begin
         @(posedge Clk);
         #1;
         if (expQ.size() > 0) begin
            monE    = expQ.pop_front();
            monName = nameQ.pop_front();
            chk({monName, ":RegWriteW"}, 32'(RegWriteW), 32'(monE.regWrite));
            chk({monName, ":MisalignW"}, 32'(MisalignW), 32'(monE.misalign));
            chk({monName, ":BusErrW"}, 32'(BusErrW), 32'(monE.busErr));
            if (monE.chkM2r) chk({monName, ":MemToRegW"}, 32'(MemToRegW), 32'(monE.memToReg));
            if (monE.chkRd) chk({monName, ":ReadDataW"}, ReadDataW, monE.readData);
            if (monE.chkData) begin
               chk({monName, ":ALUresultW"}, ALUresultW, monE.aluResult);
               chk({monName, ":WriteRegW"}, 32'(WriteRegW), 32'(monE.writeReg));
               chk({monName, ":PCPlus4W"}, PCPlus4W, monE.pcPlus4);
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : stimulus
      setM(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 32'h100, 32'h0, 5'd5, 32'h44);
      setMem(1'b0, 32'h0);
      repeat (2) @(negedge Clk);
      reqStall("reset", 1'b0, 1'b0);
      chk("reset:RegWriteW", 32'(RegWriteW), 32'h0);
      chk("reset:ALUresultW", ALUresultW, 32'h0);
      chk("reset:BusErrW", 32'(BusErrW), 32'h0);
      setM(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0);
      Rst_n = 1'b1;

      // lw 0x100, same-cycle ack
      @(negedge Clk);
      setM(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 32'h100, 32'h0, 5'd5, 32'h44);
      setMem(1'b1, 32'hDEAD_BEEF);
      #1;
      reqStall("lw0", 1'b1, 1'b0);
      chk("lw0:DMemByteEn", 32'(DMemByteEn), 32'hF);
      chk("lw0:DMemAddr", DMemAddr, 32'h100);
      chk("lw0:DMemWe", 32'(DMemWe), 32'h0);
      pushW("lw0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h100, 5'd5, 32'h44);

      // lb / lbu at 0x103, ack on the 4th request cycle
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            setM(1'b1, 1'b0, 1'b1, 1'b1, (k == 0) ? 2'b10 : 2'b11, 32'h103, 32'h0, 5'd6, 32'h48);
            setMem(c == 3, 32'h80FF_0000);
            #1;
            if (c < 3) begin
               reqStall("lbWait", 1'b1, 1'b1);
               pushBubble("lbBubble");
            end else begin
               reqStall("lbAck", 1'b1, 1'b0);
               chk("lb:DMemByteEn", 32'(DMemByteEn), 32'h8);
               pushW("lbDone", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                     (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080, 1'b1, 32'h103, 5'd6, 32'h48);
            end
         end
      end

      // sh 0x202
      @(negedge Clk);
      setM(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 32'h202, 32'h1234_ABCD, 5'd0, 32'h4C);
      setMem(1'b1, 32'h5555_5555);
      #1;
      reqStall("sh", 1'b1, 1'b0);
      chk("sh:DMemByteEn", 32'(DMemByteEn), 32'hC);
      chk("sh:DMemWData", DMemWData, 32'hABCD_ABCD);
      chk("sh:DMemWe", 32'(DMemWe), 32'h1);
      chk("sh:DMemAddr", DMemAddr, 32'h200);
      pushW("sh", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h202, 5'd0, 32'h4C);

      // sb 0x001
      @(negedge Clk);
      setM(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 32'h001, 32'h1234_ABCD, 5'd0, 32'h50);
      setMem(1'b1, 32'h0);
      #1;
      chk("sb:DMemByteEn", 32'(DMemByteEn), 32'h2);
      chk("sb:DMemWData", DMemWData, 32'hCDCD_CDCD);
      pushW("sb", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h001, 5'd0, 32'h50);

      // lh 0x102, sign-extended upper half
      @(negedge Clk);
      setM(1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 32'h102, 32'h0, 5'd8, 32'h54);
      setMem(1'b1, 32'h8001_1234);
      #1;
      chk("lh:DMemByteEn", 32'(DMemByteEn), 32'hC);
      pushW("lh", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_8001, 1'b1, 32'h102, 5'd8, 32'h54);

      // lw 0x105 misaligned, then a non-memory op with a stray ack
      @(negedge Clk);
      setM(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 32'h105, 32'h0, 5'd4, 32'h60);
      setMem(1'b0, 32'h0);
      #1;
      reqStall("misLw", 1'b0, 1'b0);
      pushW("misLw", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h105, 5'd4, 32'h60);
      @(negedge Clk);
      setM(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'hCAFE, 32'h0, 5'd7, 32'h64);
      setMem(1'b1, 32'hFFFF_FFFF);
      #1;
      reqStall("nop", 1'b0, 1'b0);
      pushW("nop", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'hCAFE, 5'd7, 32'h64);

      // lw 0x300: k=0 never acked (timeout), k=1 acked in the terminal cycle
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            setM(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 32'h300, 32'h0, 5'd3, 32'h100);
            setMem((k == 1) && (c == 4), 32'h1122_3344);
            #1;
            if (c < 4) begin
               reqStall("toWait", 1'b1, 1'b1);
               pushBubble("toBubble");
            end else if (k == 0) begin
               reqStall("toExpire", 1'b0, 1'b0);
               pushW("busErr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 5'd3, 32'h100);
            end else begin
               reqStall("ackWins", 1'b1, 1'b0);
               pushW("ackWins", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1122_3344, 1'b1, 32'h300, 5'd3, 32'h100);
            end
         end
         @(negedge Clk);
         setM(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h77, 32'h0, 5'd2, 32'h104);
         setMem(1'b0, 32'h0);
         #1;
         reqStall("afterTo", 1'b0, 1'b0);
         pushW("afterTo", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h77, 5'd2, 32'h104);
      end

      // reset asserted while in WAIT
      @(negedge Clk);
      setM(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 32'h400, 32'h0, 5'd9, 32'h200);
      setMem(1'b0, 32'h0);
      #1;
      reqStall("rstStart", 1'b1, 1'b1);
      pushBubble("rstBubble");
      @(negedge Clk);
      #1;
      reqStall("rstWait", 1'b1, 1'b1);
      Rst_n = 1'b0;
      #1;
      reqStall("rstMid", 1'b0, 1'b0);
      chk("rstMid:ALUresultW", ALUresultW, 32'h0);
      chk("rstMid:PCPlus4W", PCPlus4W, 32'h0);
      chk("rstMid:WriteRegW", 32'(WriteRegW), 32'h0);
      @(negedge Clk);
      setM(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h1234, 32'h0, 5'd9, 32'h90);
      Rst_n = 1'b1;
      #1;
      reqStall("postRst", 1'b0, 1'b0);
      pushW("postRst", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h1234, 5'd9, 32'h90);

      repeat (2) @(negedge Clk);
      chk("scoreboardDrained", 32'(expQ.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage that consumes the EX/MEM register outputs (M-stage signals) and drives a variable-latency data memory over a req/ack handshake.
- Performs byte/half/word lane steering, byte-enable generation and load extension.
- Stalls the pipeline while an access is outstanding and registers the results into the MEM/WB (W-stage) outputs for writeback.

Parameters:
- TIMEOUT, 64, cycles waiting for DMemAck before the access is abandoned with a bus error; legal range 1..255.

Ports:
- Clk  input  1  Clock; all state updates on the rising edge.
- Rst_n  input  1  Asynchronous, active-low reset.
- MemReadM, MemWriteM, MemToRegM, RegWriteM  input  1 each  M-stage control.
- MemTypeM  input  2  00 word, 01 half sign-extended, 10 byte sign-extended, 11 byte zero-extended.
- ALUresultM  input  32  Effective address, or the result for non-memory instructions.
- ReadData2M  input  32  Store data.
- WriteRegM  input  5  Destination register.
- PCPlus4M  input  32  Passed through to W.
- StallM  output  1  Upstream holds all M inputs stable while this is high.
- DMemReq  output  1  Memory request.
- DMemWe  output  1  1 = write.
- DMemAddr  output  32  Word address: {ALUresultM[31:2],2'b00}.
- DMemWData  output  32  Lane-replicated store data.
- DMemByteEn  output  4  Byte lanes; lane k = bits 8k+7:8k, little-endian.
- DMemAck  input  1  Access complete; DMemRData valid in the same cycle.
- DMemRData  input  32  Read data.
- RegWriteW, MemToRegW  output  1 each  W-stage control.
- ALUresultW, ReadDataW, PCPlus4W  output  32 each  W-stage data; ReadDataW is extended.
- WriteRegW  output  5  W-stage destination register.
- MisalignW, BusErrW  output  1 each  One-cycle exception flags, aligned with the W slot.

Behaviour:
- Reset (Rst_n low, asynchronous): FSM to IDLE, counter cleared, every W output 0; DMemReq and StallM forced 0 immediately, including mid-access. After release, the M inputs then present are treated as a new access.
- Access = MemReadM|MemWriteM. If both are high, treat it as a write.
- Misaligned = (half & a[0]) or (word & a[1:0]!=0), where a = ALUresultM[1:0].
  - No DMemReq is issued; no stall.
  - Next edge: MisalignW=1, RegWriteW=0, WriteRegW/PCPlus4W/ALUresultW loaded normally.
- Byte enables:
  - Word: 1111.
  - Half: a[1]? 1100 : 0011.
  - Byte: 0001<<a.
- Store data: word as-is; half {2{ReadData2M[15:0]}}; byte {4{ReadData2M[7:0]}}.
- Load data: select the lane at offset a, then sign- or zero-extend per MemTypeM.
- FSM states:
  - IDLE: a legal access drives DMemReq=1 combinationally in the same cycle.
    - If DMemAck=1 that cycle: StallM=0, W loads on the edge (1-cycle access, zero stall), stay in IDLE.
    - Otherwise: StallM=1, go to WAIT, counter=1.
  - WAIT: DMemReq held at 1, address, data and enables unchanged, StallM=1. Counter increments each cycle.
    - DMemAck=1: StallM=0 that cycle, W loads, return to IDLE.
    - Counter==TIMEOUT without ack: DMemReq drops, StallM=0, next edge BusErrW=1 with RegWriteW=0, return to IDLE.
    - Ack in the same cycle the counter reaches TIMEOUT: ack wins, no BusErrW.
- W register while StallM=1: loads a bubble every edge (RegWriteW=0, MemToRegW=0, flags 0).
- Non-memory instruction: no request, no stall; W loads the M inputs on the next edge, with ReadDataW=0.
- DMemAck outside a request: ignored.
- Write accesses load ReadDataW=0 and pass RegWriteM through unchanged.

Test Plan:
- Load word, ALUresultM=0x100, ack in the same cycle -> DMemReq=1, DMemByteEn=1111, StallM=0; next edge ReadDataW=DMemRData, RegWriteW=1.
- lb at 0x103, DMemRData=0x80FF_0000, ack after 3 cycles -> StallM high for 3 cycles, RegWriteW=0 bubbles during the stall, then ReadDataW=0xFFFF_FF80. The same access with MemTypeM=11 -> ReadDataW=0x0000_0080.
- sh at 0x202, ReadData2M=0x1234_ABCD -> DMemByteEn=1100, DMemWData=0xABCD_ABCD, DMemWe=1, DMemAddr=0x200.
- lw at 0x105 -> no DMemReq, no stall; next edge MisalignW=1, RegWriteW=0.
- No ack, TIMEOUT=4 -> StallM high for 4 cycles, then BusErrW pulses for 1 cycle, RegWriteW=0, FSM back in IDLE. Repeat with ack on cycle 4 -> normal completion, BusErrW=0.
- Rst_n low during WAIT -> DMemReq, StallM and all W outputs 0 immediately. After release, a non-memory instruction passes through in 1 cycle.
